// File: rtl/waveform_analyzer.sv
// Sample-stream period and amplitude analyzer: detects rising mid-level crossings
// with hysteresis and reports period, min, max and peak-to-peak per full cycle.
module waveform_analyzer #(
    parameter int MID   = 128,
    parameter int HYST  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       sample,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       min_val,
    output logic [7:0]       max_val,
    output logic [7:0]       amplitude,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [7:0]       LO      = 8'(MID - HYST);
    localparam logic [7:0]       HI      = 8'(MID + HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_WAIT_LOW,
        S_WAIT_RISE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       min_val_q, min_val_d;
    logic [7:0]       max_val_q, max_val_d;
    logic [7:0]       amplitude_q, amplitude_d;
    logic             meas_valid_q, meas_valid_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic is_low, is_high, cnt_sat;
    logic [7:0] upd_min, upd_max;

    assign is_low  = (sample <= LO);
    assign is_high = (sample >= HI);
    assign cnt_sat = (cnt_q == CNT_MAX);
    assign upd_min = (sample < run_min_q) ? sample : run_min_q;
    assign upd_max = (sample > run_max_q) ? sample : run_max_q;

    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        run_min_d    = run_min_q;
        run_max_d    = run_max_q;
        period_d     = period_q;
        min_val_d    = min_val_q;
        max_val_d    = max_val_q;
        amplitude_d  = amplitude_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (in_valid) begin
            case (state_q)
                S_WAIT_LOW: begin
                    if (is_low) state_d = S_WAIT_RISE;
                end
                S_WAIT_RISE: begin
                    if (is_high) begin
                        cnt_d     = CNT_ONE;
                        run_min_d = sample;
                        run_max_d = sample;
                        state_d   = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (cnt_sat) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_WAIT_LOW;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                        run_min_d = upd_min;
                        run_max_d = upd_max;
                        if (is_low) state_d = S_LOW;
                    end
                end
                S_LOW: begin
                    if (is_high) begin
                        // The crossing sample closes this window and opens the next one.
                        period_d     = cnt_q;
                        min_val_d    = run_min_q;
                        max_val_d    = run_max_q;
                        amplitude_d  = run_max_q - run_min_q;
                        meas_valid_d = 1'b1;
                        cnt_d        = CNT_ONE;
                        run_min_d    = sample;
                        run_max_d    = sample;
                        state_d      = S_HIGH;
                    end else if (cnt_sat) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_WAIT_LOW;
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                        run_min_d = upd_min;
                        run_max_d = upd_max;
                    end
                end
                default: state_d = S_WAIT_LOW;
            endcase
        end

        busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT_LOW;
            cnt_q        <= '0;
            run_min_q    <= 8'hFF;
            run_max_q    <= 8'h00;
            period_q     <= '0;
            min_val_q    <= 8'h00;
            max_val_q    <= 8'h00;
            amplitude_q  <= 8'h00;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_min_q    <= run_min_d;
            run_max_q    <= run_max_d;
            period_q     <= period_d;
            min_val_q    <= min_val_d;
            max_val_q    <= max_val_d;
            amplitude_q  <= amplitude_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign period     = period_q;
    assign min_val    = min_val_q;
    assign max_val    = max_val_q;
    assign amplitude  = amplitude_q;
    assign meas_valid = meas_valid_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;

endmodule

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
Sample-stream measurement block, the receive-side counterpart of the waveform generator. It consumes 8-bit samples from a source such as the generator's selected output or a loopback ADC. It detects rising mid-level crossings with hysteresis, then measures period (in accepted samples), minimum, maximum and peak-to-peak amplitude over each full cycle. Results feed the lab display/checker logic.

Parameters:
MID, 128, mid-level crossing reference (unsigned 8-bit)
HYST, 4, hysteresis half-band; LO = MID-HYST, HI = MID+HYST (require HYST < MID, MID+HYST <= 255)
CNT_W, 16, width of period counter and period output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  sample qualifier; sample accepted on a clk edge with in_valid=1
sample  input  8  unsigned input sample
period  output  CNT_W  last measured period in accepted samples
min_val  output  8  minimum sample over last measured period
max_val  output  8  maximum sample over last measured period
amplitude  output  8  max_val - min_val of last measured period
meas_valid  output  1  one-cycle pulse when period/min/max/amplitude update
timeout  output  1  one-cycle pulse when period counter saturates
busy  output  1  high in S_HIGH or S_LOW (measurement window open)

Behaviour:
- Interface as decided: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: state=S_WAIT_LOW; period=0, min_val=0, max_val=0, amplitude=0, meas_valid=0, timeout=0, busy=0; internal cnt=0, run_min=255, run_max=0.
- in_valid=0: no state, counter or running-extreme change; meas_valid/timeout deassert.
- "Low" sample: sample <= LO. "High" sample: sample >= HI. Samples strictly between LO and HI never change state.
- S_WAIT_LOW: on a low sample -> S_WAIT_RISE.
- S_WAIT_RISE: on a high sample: cnt<=1, run_min<=sample, run_max<=sample -> S_HIGH.
- S_HIGH: each accepted sample: cnt<=cnt+1, update run_min/run_max. A low sample -> S_LOW.
- S_LOW, non-high sample: cnt<=cnt+1, update run_min/run_max.
- S_LOW, high sample (period end): period<=cnt, min_val<=run_min, max_val<=run_max, amplitude<=run_max-run_min, meas_valid<=1. The crossing sample opens the next window: cnt<=1, run_min<=run_max<=sample. -> S_HIGH.
- Window content: period counts all accepted samples from a rising-crossing sample up to, but excluding, the next one. min/max cover the same set.
- Latency: outputs and meas_valid are registered and change on the clock edge that accepts the completing sample. meas_valid is high for exactly one cycle.
- Saturation: in S_HIGH or S_LOW, if cnt = 2^CNT_W-1 and another non-completing sample is accepted: timeout<=1 for one cycle, -> S_WAIT_LOW, cnt<=0. period/min_val/max_val/amplitude hold previous values. A completing sample at cnt = 2^CNT_W-1 completes normally, with no timeout.
- Subtraction is 8-bit unsigned; run_max >= run_min is guaranteed, so there is no wrap.
- Reset mid-measurement discards the partial window and returns all outputs to reset values on the next edge.
- busy = (state==S_HIGH || state==S_LOW), registered with state.

Test Plan:
- Square wave, MID=128/HYST=4: repeat [0 x8, 255 x8], in_valid=1 -> first meas_valid one edge after the 2nd rising sample; period=16, min_val=0, max_val=255, amplitude=255. Pulse recurs every 16 cycles.
- Triangle: ramp 0..255 then 254..1, repeated (period 510) -> period=510, min_val=0, max_val=255, amplitude=255.
- Hysteresis: square 100/160 with a 130 glitch sample injected in the low phase -> no extra crossing; period unchanged. The 130 sample is counted and reflected in the extremes.
- Stall: square [0 x4, 200 x4] with in_valid toggled 1/0 each cycle -> period=8 (accepted samples only); meas_valid spacing is 16 clocks.
- Timeout, CNT_W=8: one low sample, one high sample, then constant 200 -> timeout pulse when the 256th sample of the window is accepted; state S_WAIT_LOW, busy=0; previous results held.
- Reset mid-window: assert rst for 1 cycle during S_LOW -> all outputs 0, busy=0. Measurement resumes only after a new low then high sample.
